// File: rtl/mult_pkg.sv
// Shared encodings and default sizing for the sequential shift-and-add multiplier.
package mult_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 5;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Request/result handshake between a multiply client and mult_seq_ctrl.
interface mult_seq_ctrl_if #(
  parameter int WIDTH = mult_pkg::DEF_WIDTH
);
  logic               start;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (output start, mcand, mplier, input busy, done, product);
  modport slave  (input start, mcand, mplier, output busy, done, product);
endinterface

// File: rtl/mult_seq_dp.sv
// Multiplier datapath: product/multiplier register P, multiplicand M and iteration
// counter, plus the operand hookup for the externally shared adder.
module mult_seq_dp
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift_en,
  input  logic               active,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_co,
  output logic [2*WIDTH-1:0] p,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               last
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] p_r;
  logic [WIDTH-1:0]   m_r;
  logic [CNT_W-1:0]   cnt_r;

  // P, M and counter: load on accepted start, shift in the adder result on each grant
  always_ff @(posedge clk) begin
    if (rst) begin
      p_r   <= {(2*WIDTH){1'b0}};
      m_r   <= {WIDTH{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      p_r   <= {{WIDTH{1'b0}}, mplier};
      m_r   <= mcand;
      cnt_r <= {CNT_W{1'b0}};
    end else if (shift_en) begin
      // carry-out lands in the top bit so no partial-sum bit is ever lost
      p_r   <= {add_co, add_sum, p_r[WIDTH-1:1]};
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      p_r   <= p_r;
      m_r   <= m_r;
      cnt_r <= cnt_r;
    end
  end

  assign p     = p_r;
  assign add_a = active ? p_r[2*WIDTH-1:WIDTH] : {WIDTH{1'b0}};
  assign add_b = (active && p_r[0]) ? m_r : {WIDTH{1'b0}};
  assign last  = (cnt_r == LAST_CNT);

endmodule

// File: rtl/mult_seq_ctrl.sv
// Iterative unsigned multiplier controller: sequences a shared WIDTH-bit adder
// over WIDTH granted cycles to form a 2*WIDTH-bit product.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  mult_seq_ctrl_if.slave    bus,
  output logic              add_req,
  input  logic              add_gnt,
  output logic [WIDTH-1:0]  add_a,
  output logic [WIDTH-1:0]  add_b,
  output logic              add_ci,
  input  logic [WIDTH-1:0]  add_sum,
  input  logic              add_co
);

  logic [1:0] state_r;
  logic [1:0] state_nx_s;
  logic       busy_r;
  logic       done_r;
  logic       add_req_r;
  logic       load_s;
  logic       shift_en_s;
  logic       last_s;
  logic       run_s;

  assign run_s = (state_r == S_RUN);

  // Next state plus datapath strobes; start is only honoured in IDLE and DONE
  always_comb begin
    state_nx_s = state_r;
    load_s     = 1'b0;
    shift_en_s = 1'b0;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          load_s     = 1'b1;
          state_nx_s = S_RUN;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (add_gnt) begin
          shift_en_s = 1'b1;
          state_nx_s = last_s ? S_DONE : S_RUN;
        end else begin
          state_nx_s = S_RUN;
        end
      end
      default: begin
        state_nx_s = S_IDLE;
      end
    endcase
  end

  // State register with status flags registered alongside the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      add_req_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      busy_r    <= (state_nx_s == S_RUN);
      done_r    <= (state_nx_s == S_DONE);
      add_req_r <= (state_nx_s == S_RUN);
    end
  end

  mult_seq_dp #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .shift_en (shift_en_s),
    .active   (run_s),
    .mcand    (bus.mcand),
    .mplier   (bus.mplier),
    .add_sum  (add_sum),
    .add_co   (add_co),
    .p        (bus.product),
    .add_a    (add_a),
    .add_b    (add_b),
    .last     (last_s)
  );

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign add_req  = add_req_r;
  assign add_ci   = 1'b0;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl: behavioural adder, per-cycle grant masks,
// expected product and done cycle queued at start, checked by an independent monitor.
module tb_mult_seq_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         add_req;
  logic         add_gnt = 1'b0;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic         add_ci;
  logic [W-1:0] add_sum;
  logic         add_co;

  mult_seq_ctrl_if #(.WIDTH(W)) bus ();

  mult_seq_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .add_req (add_req),
    .add_gnt (add_gnt),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_ci  (add_ci),
    .add_sum (add_sum),
    .add_co  (add_co)
  );

  always #5 clk = ~clk;

  // shared adder stand-in
  assign {add_co, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_ci};

  typedef struct {
    logic [2*W-1:0] prod;
    int             start_e;
    int             done_e;
  } exp_t;

  exp_t              sb[$];
  int                cyc = 0;
  int                total = 0;
  int                bad = 0;
  int                cur_e = -1000;
  int                last_done_e = -1;
  logic [63:0]       gnt_mask = 64'd0;
  logic [2*W-1:0]    held = {(2*W){1'b0}};
  bit                mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: expected status from the front of the scoreboard
  always @(negedge clk) begin
    logic eb;
    logic ed;
    if (mon_en) begin
      eb = (sb.size() > 0) && (cyc >= sb[0].start_e) && (cyc < sb[0].done_e);
      ed = (sb.size() > 0) && (cyc == sb[0].done_e);
      chk("busy", 64'(bus.busy), 64'(eb));
      chk("add_req", 64'(add_req), 64'(eb));
      chk("add_ci", 64'(add_ci), 64'd0);
      if (!eb) chk("idle_operands", {32'd0, add_a, add_b}, 64'd0);
      chk("done", 64'(bus.done), 64'(ed));
      if (ed) begin
        chk("product", 64'(bus.product), 64'(sb[0].prod));
        held = sb[0].prod;
        void'(sb.pop_front());
      end else if (sb.size() == 0 || cyc < sb[0].start_e) begin
        chk("product_hold", 64'(bus.product), 64'(held));
      end
    end
  end

  task automatic tick();
    int j;
    @(negedge clk);
    #2;
    j = cyc - cur_e;
    if (j >= 0 && j < 64) add_gnt = gnt_mask[j];
    else                  add_gnt = 1'($urandom_range(1, 0));
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    bus.start = 1'b1;
    sb.delete();
    cur_e = -1000;
    last_done_e = -1;
    held = {(2*W){1'b0}};
    tick();
    rst = 1'b0;
    bus.start = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [63:0] mask);
    int e;
    int ones;
    int jj;
    exp_t x;
    tick();
    bus.start  = 1'b1;
    bus.mcand  = a;
    bus.mplier = b;
    e = cyc + 1;
    if (e > last_done_e) begin
      ones = 0;
      jj = 0;
      for (int i = 0; i < 64; i++) begin
        if (mask[i] && ones < W) begin
          ones++;
          jj = i;
        end
      end
      if (ones < W) begin
        mask = {64{1'b1}};
        jj = W - 1;
      end
      x.prod    = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      x.start_e = e;
      x.done_e  = e + 1 + jj;
      sb.push_back(x);
      last_done_e = x.done_e;
      cur_e = e;
      gnt_mask = mask;
    end
    tick();
    bus.start  = 1'b0;
    bus.mcand  = W'($urandom);
    bus.mplier = W'($urandom);
  endtask

  task automatic wait_until(input int target);
    for (int k = 0; k < 400 && cyc < target; k++) tick();
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(5, 0))
      0:       return {W{1'b0}};
      1:       return {W{1'b1}};
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    logic [63:0] m;
    bus.start  = 1'b0;
    bus.mcand  = {W{1'b0}};
    bus.mplier = {W{1'b0}};
    do_reset();
    repeat (2) tick();

    issue(16'd3, 16'd5, {64{1'b1}});
    wait_until(last_done_e + 2);
    issue(16'hFFFF, 16'hFFFF, {64{1'b1}});
    wait_until(last_done_e + 2);
    issue(16'h1234, 16'h0010, 64'h5555_5555_5555_5555);
    wait_until(last_done_e + 2);

    // start while busy is dropped, start in the DONE cycle is taken
    issue(16'd3, 16'd5, {64{1'b1}});
    repeat (3) tick();
    issue(16'd7, 16'd9, {64{1'b1}});
    wait_until(last_done_e - 1);
    issue(16'd7, 16'd9, {64{1'b1}});
    wait_until(last_done_e + 2);

    issue(16'hABCD, 16'h0002, {64{1'b1}});
    repeat (6) tick();
    do_reset();
    issue(16'd2, 16'd2, {64{1'b1}});
    wait_until(last_done_e + 2);

    issue(16'h0000, 16'hFFFF, {64{1'b1}});
    wait_until(last_done_e + 1);
    issue(16'hFFFF, 16'h0000, 64'h3333_3333_3333_3333);
    wait_until(last_done_e + 1);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(2, 0))
        0:       m = {64{1'b1}};
        1:       m = {$urandom, $urandom};
        default: m = {$urandom, $urandom} | {$urandom, $urandom};
      endcase
      issue(rand_op(), rand_op(), m);
      if ($urandom_range(3, 0) == 0) begin
        repeat ($urandom_range(12, 1)) tick();
        issue(rand_op(), rand_op(), {64{1'b1}});
      end
      if ($urandom_range(1, 0) == 0) wait_until(last_done_e - 1);
      else                           wait_until(last_done_e + int'($urandom_range(3, 0)));
    end

    wait_until(last_done_e + 3);
    chk("drain", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Iterative unsigned shift-and-add multiplier controller.
- Does not own an adder. It sequences one shared WIDTH-bit carry-look-ahead adder instance, built from the existing CLA full-adder cells, to compute a 2*WIDTH-bit product over WIDTH granted cycles.
- Sits beside the ALU in EX. The ALU and this block share the adder; the arbiter drives add_gnt.

Parameters:
- WIDTH, 16, operand width in bits; product is 2*WIDTH bits.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a multiply
- mcand  in  WIDTH  multiplicand, sampled when start is accepted
- mplier  in  WIDTH  multiplier, sampled when start is accepted
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when product becomes valid
- product  out  2*WIDTH  result; held stable from done until the next accepted start
- add_req  out  1  request for the shared adder
- add_gnt  in  1  adder granted this cycle
- add_a  out  WIDTH  adder operand A
- add_b  out  WIDTH  adder operand B
- add_ci  out  1  adder carry-in; constant 0
- add_sum  in  WIDTH  adder sum, combinational from add_a, add_b and add_ci
- add_co  in  1  adder carry-out

Behaviour:
- Reset: the following are all 0 at the next edge:
  - state = IDLE
  - busy, done, add_req
  - product register P (2*WIDTH bits)
  - mcand register M
  - counter
- Reset mid-operation aborts with no done pulse.
- States: IDLE, RUN, DONE. State is held in a 2-bit register.
- IDLE:
  - busy=0, add_req=0.
  - If start=1: M<=mcand, P<={WIDTH'b0, mplier}, cnt<=0, go to RUN.
- RUN:
  - busy=1, add_req=1.
  - add_a=P[2W-1:W]; add_b = P[0] ? M : 0; add_ci=0.
  - If add_gnt=1: P<={add_co, add_sum, P[W-1:1]}, cnt<=cnt+1. If cnt==WIDTH-1, go to DONE.
  - If add_gnt=0: P and cnt hold (stall), no timeout, stay in RUN.
- DONE:
  - done=1 for exactly this one cycle, busy=0, add_req=0.
  - If start=1: accepted as in IDLE, go to RUN (back-to-back).
  - Otherwise go to IDLE.
- Outputs when not in RUN: add_a and add_b drive 0.
- product is continuously P. It is valid from the DONE cycle until the cycle after the next accepted start.
- start is ignored while in RUN, with no queuing. A request that arrives then is lost; the caller must wait for done.
- Latency with continuous grant: start sampled at edge 0, RUN for edges 1..WIDTH, done high in cycle WIDTH+1. That is 17 cycles at WIDTH=16. Each cycle with add_gnt=0 adds one cycle.
- Arithmetic:
  - Unsigned only; no overflow is possible in 2*WIDTH bits.
  - The carry-out of each partial add is shifted into P[2W-1] and is never dropped.
- Operand edge cases:
  - mplier=0: all adds use add_b=0; full latency still applies, with no early exit.
  - mcand=0: same, product=0.
- Simultaneous start and rst: rst wins.
- Grant behaviour: add_gnt is a don't-care outside RUN. A grant while add_req=0 has no effect.

Decomposition:
- Shared package mult_pkg holds:
  - state encodings S_IDLE=2'b00, S_RUN=2'b01, S_DONE=2'b10
  - default WIDTH=16 and CNT_W=5
- Natural sub-module mult_seq_dp holds P, M and the counter, with load, shift_en and adder hookup.
- mult_seq_ctrl holds the FSM and the handshake, and instantiates mult_seq_dp.
- The adder stays outside both modules.

Test Plan:
- Basic, with add_gnt tied 1: mcand=3, mplier=5, start pulse -> add_req high for 16 cycles; done in cycle 17; product=0x0000000F.
- Carry-out path: 0xFFFF x 0xFFFF -> product=0xFFFE0001, done at cycle 17.
- Grant stalls: 0x1234 x 0x0010 with add_gnt alternating 1,0 starting at 1 -> done in cycle 32; product=0x00012340; P is unchanged on every gnt=0 cycle.
- Busy-time start: second start (7 x 9) pulsed at cycle 5 of an active 3 x 5 -> ignored; product=0x0F; then a start in the DONE cycle with 7 x 9 -> accepted; second done 17 cycles later; product=0x3F.
- Reset mid-op: rst at cycle 8 of 0xABCD x 0x0002 -> next edge state=IDLE, P=0, busy=0, add_req=0, no done pulse; a subsequent 2 x 2 yields 4.
- Zero operand: mcand=0, mplier=0xFFFF -> product=0 at full 17-cycle latency.
